// File: rtl/bus_regfile_pkg.sv
// rtl/bus_regfile_pkg.sv - shared FSM state type and field-select indices for bus_regfile
package bus_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // p[0..num_rd-1] select read addresses; the two fields above them follow.
  function automatic int wa_sel(input int num_rd);
    return num_rd;
  endfunction

  function automatic int wd_sel(input int num_rd);
    return num_rd + 1;
  endfunction

endpackage

// File: rtl/bus_regfile_fsm.sv
// rtl/bus_regfile_fsm.sv - commit/clear sequencer driving the array write port
// Exposes fwd (WRITE in progress) only when BUS_REGFILE_BYPASS_EN is defined.
module bus_regfile_fsm
  import bus_regfile_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r,
  input  logic              clr,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic              busy,
  output logic              ack,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
`ifdef BUS_REGFILE_BYPASS_EN
  ,
  output logic              fwd
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] ca_q;
  logic [DATA_W-1:0] cd_q;
  logic              ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ca_q    <= '0;
      cd_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_q == WRITE);
      if (state_q == IDLE && clr) begin
        cnt_q <= '0;
      end else if (state_q == CLEAR && cnt_q != LAST) begin
        cnt_q <= cnt_q + ADDR_W'(1);
      end
      // Snapshot isolates the in-flight write from later field loads.
      if (state_q == IDLE && !clr && r) begin
        ca_q <= wa;
        cd_q <= wd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    we      = 1'b0;
    waddr   = ca_q;
    wdata   = cd_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
        end else if (r) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy    = 1'b1;
        we      = 1'b1;
        state_d = IDLE;
      end
      CLEAR: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack = ack_q;

`ifdef BUS_REGFILE_BYPASS_EN
  assign fwd = (state_q == WRITE);
`endif

endmodule

// File: rtl/bus_regfile.sv
// rtl/bus_regfile.sv - bus-loaded register file with NUM_RD async read ports
// Optional write-to-read forwarding under BUS_REGFILE_BYPASS_EN.
module bus_regfile
  import bus_regfile_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        b,
  input  logic [NUM_RD+1:0]        p,
  input  logic                     r,
  input  logic                     clr,
  output logic                     busy,
  output logic                     ack,
  output logic [NUM_RD*DATA_W-1:0] w
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int P_W    = NUM_RD + 2;
  localparam int WA_SEL = wa_sel(NUM_RD);
  localparam int WD_SEL = wd_sel(NUM_RD);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra_q [NUM_RD];
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic [P_W-1:0]    p_low;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              waddr_ok;
  logic [NUM_RD-1:0] rd_ok;
`ifdef BUS_REGFILE_BYPASS_EN
  logic              fwd;
`endif

  // Isolate the lowest set select bit; higher bits lose.
  assign p_low = p & (~p + P_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RD; i++) begin
        ra_q[i] <= '0;
      end
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (p_low[i]) begin
          ra_q[i] <= b[ADDR_W-1:0];
        end
      end
      if (p_low[WA_SEL]) begin
        wa_q <= b[ADDR_W-1:0];
      end
      if (p_low[WD_SEL]) begin
        wd_q <= b;
      end
    end
  end

  bus_regfile_fsm #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fsm (
    .clk  (clk),
    .rst  (rst),
    .r    (r),
    .clr  (clr),
    .wa   (wa_q),
    .wd   (wd_q),
    .busy (busy),
    .ack  (ack),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata)
`ifdef BUS_REGFILE_BYPASS_EN
    ,
    .fwd  (fwd)
`endif
  );

  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign waddr_ok = 1'b1;
    assign rd_ok    = '1;
  end else begin : g_npow2
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    assign waddr_ok = ({1'b0, waddr} < DEPTH_C);
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      assign rd_ok[i] = ({1'b0, ra_q[i]} < DEPTH_C);
    end
  end

  // Reset on the write edge aborts both a pending commit and the sweep step.
  always_ff @(posedge clk) begin
    if (!rst && we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    w = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_ok[i]) begin
        w[i*DATA_W +: DATA_W] = mem[ra_q[i]];
`ifdef BUS_REGFILE_BYPASS_EN
        if (fwd && ra_q[i] == waddr) begin
          w[i*DATA_W +: DATA_W] = wdata;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_bus_regfile.sv
// tb/tb_bus_regfile.sv - directed plus randomized check of bus_regfile against a behavioural model
module tb_bus_regfile;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
  localparam int NUM_RD = 2;
  localparam int P_W    = NUM_RD + 2;
`ifdef BUS_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [P_W-1:0] P_RD0 = 4'b0001;
  localparam logic [P_W-1:0] P_RD1 = 4'b0010;
  localparam logic [P_W-1:0] P_WA  = 4'b0100;
  localparam logic [P_W-1:0] P_WD  = 4'b1000;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [DATA_W-1:0]        b   = '0;
  logic [P_W-1:0]           p   = '0;
  logic                     r   = 1'b0;
  logic                     clr = 1'b0;
  logic                     busy;
  logic                     ack;
  logic [NUM_RD*DATA_W-1:0] w;

  bus_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk (clk),
    .rst (rst),
    .b   (b),
    .p   (p),
    .r   (r),
    .clr (clr),
    .busy(busy),
    .ack (ack),
    .w   (w)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  int m_mem   [DEPTH];
  bit m_known [DEPTH];
  int m_ra    [NUM_RD];
  int m_wa, m_wd;
  bit m_pend, m_clearing, m_ack;
  int m_paddr, m_pdata, m_cidx;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model of one clock edge, from the current input values.
  task automatic model_step();
    bit nack;
    if (rst) begin
      for (int i = 0; i < NUM_RD; i++) m_ra[i] = 0;
      m_wa = 0; m_wd = 0; m_pend = 0; m_clearing = 0; m_ack = 0;
      return;
    end
    nack = 0;
    if (m_pend) begin
      if (m_paddr < DEPTH) begin
        m_mem[m_paddr] = m_pdata;
        m_known[m_paddr] = 1;
      end
      m_pend = 0;
      nack = 1;
    end else if (m_clearing) begin
      m_mem[m_cidx] = 0;
      m_known[m_cidx] = 1;
      m_cidx++;
      if (m_cidx == DEPTH) m_clearing = 0;
    end else if (clr) begin
      m_clearing = 1;
      m_cidx = 0;
    end else if (r) begin
      m_pend = 1;
      m_paddr = m_wa;
      m_pdata = m_wd;
    end
    for (int i = 0; i < P_W; i++) begin
      if (p[i]) begin
        if (i < NUM_RD) m_ra[i] = int'(b);
        else if (i == NUM_RD) m_wa = int'(b);
        else m_wd = int'(b);
        break;
      end
    end
    m_ack = nack;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_pend || m_clearing)});
      chk("ack", {31'd0, ack}, {31'd0, m_ack});
      for (int i = 0; i < NUM_RD; i++) begin
        if (BYPASS && m_pend && m_ra[i] == m_paddr) begin
          chk("w_fwd", 32'(w[i*DATA_W +: DATA_W]), 32'(m_pdata));
        end else if (m_ra[i] < DEPTH && m_known[m_ra[i]]) begin
          chk("w", 32'(w[i*DATA_W +: DATA_W]), 32'(m_mem[m_ra[i]]));
        end
      end
    end
  end

  // Called at a negedge; applies inputs for one edge and returns at the next negedge.
  task automatic cyc(input logic [P_W-1:0] pp, input int bb, input logic rr,
                     input logic cc, input logic rs);
    p = pp; b = DATA_W'(bb); r = rr; clr = cc; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic commit(input int a, input int d);
    cyc(P_WA, a, 0, 0, 0);
    cyc(P_WD, d, 0, 0, 0);
    cyc('0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 0);
  endtask

  int busy_cnt;
  bit ack_seen;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0;
      m_known[i] = 0;
    end
    @(negedge clk);
    cyc('0, 0, 0, 0, 1);
    cyc('0, 0, 0, 0, 1);
    cmp_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);

    // Scenario 1 and 2: commit, then a data load during WRITE must not leak in.
    cyc(P_WA, 5, 0, 0, 0);
    cyc(P_WD, 4'hA, 0, 0, 0);
    cyc('0, 0, 1, 0, 0);
    chk("s1_busy_write", {31'd0, busy}, 32'd1);
    chk("s1_no_early_ack", {31'd0, ack}, 32'd0);
    cyc(P_WD, 3, 0, 0, 0);
    chk("s1_ack", {31'd0, ack}, 32'd1);
    chk("s1_busy_done", {31'd0, busy}, 32'd0);
    cyc(P_RD0, 5, 0, 0, 0);
    chk("s1_rd0", 32'(w[3:0]), 32'hA);
    chk("s1_ack_oneshot", {31'd0, ack}, 32'd0);

    // Scenario 3: multiple select bits, only the lowest loads.
    cyc(P_RD1, 5, 0, 0, 0);
    cyc(4'b0011, 7, 0, 0, 0);
    chk("s3_rd1_unchanged", 32'(w[7:4]), 32'hA);

    // Scenario 4: clr and r together; clear wins.
    cyc(P_WA, 1, 0, 0, 0);
    cyc(P_WD, 4'hF, 0, 0, 0);
    cyc('0, 0, 1, 1, 0);
    busy_cnt = 0;
    ack_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy) busy_cnt++;
      if (ack) ack_seen = 1;
      if (!busy && busy_cnt > 0) break;
      cyc('0, 0, 0, 0, 0);
    end
    chk("s4_busy_len", 32'(busy_cnt), 32'd16);
    chk("s4_no_ack", {31'd0, ack_seen}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(P_RD0, i, 0, 0, 0);
      chk("s4_cleared", 32'(w[3:0]), 32'd0);
    end

    // Scenario 5: reset in the 8th busy cycle of a sweep.
    for (int i = 0; i < DEPTH; i++) commit(i, (i ^ 5) & 15);
    cyc('0, 0, 0, 1, 0);
    for (int n = 0; n < 7; n++) cyc('0, 0, 0, 0, 0);
    cyc('0, 0, 0, 0, 1);
    chk("s5_busy", {31'd0, busy}, 32'd0);
    chk("s5_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(P_RD0, i, 0, 0, 0);
      chk("s5_entry", 32'(w[3:0]), (i < 7) ? 32'd0 : 32'((i ^ 5) & 15));
    end

    // Scenario 6: write-to-read visibility on port 1.
    cyc(P_RD1, 2, 0, 0, 0);
    cyc(P_WA, 2, 0, 0, 0);
    cyc(P_WD, 9, 0, 0, 0);
    cyc('0, 0, 1, 0, 0);
    chk("s6_write_cycle", 32'(w[7:4]), BYPASS ? 32'd9 : 32'd0);
    cyc('0, 0, 0, 0, 0);
    chk("s6_after_write", 32'(w[7:4]), 32'd9);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic [P_W-1:0] rp;
      rp = P_W'($urandom);
      if ($urandom_range(0, 3) == 0) rp = '0;
      cyc(rp, int'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 60) == 0), ($urandom_range(0, 250) == 0));
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
